// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state codes, ALU operation codes and MIPS Op/Funct constants
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// mc_ctrl_alu_dec: combinational Op/Funct decoder giving ALU op, extension mode, shift flag and legality
module mc_ctrl_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic [3:0] aluop,
    output logic       extop,
    output logic       is_shift,
    output logic       legal
);

    always_comb begin
        aluop    = ALU_NOP;
        extop    = 1'b0;
        is_shift = 1'b0;
        legal    = 1'b1;
        case (Op)
            OP_RTYPE: case (Funct)
                FN_ADD, FN_ADDU: aluop = ALU_ADD;
                FN_SUB, FN_SUBU: aluop = ALU_SUB;
                FN_AND:          aluop = ALU_AND;
                FN_OR:           aluop = ALU_OR;
                FN_XOR:          aluop = ALU_XOR;
                FN_NOR:          aluop = ALU_NOR;
                FN_SLT:          aluop = ALU_SLT;
                FN_SLTU:         aluop = ALU_SLTU;
                FN_SLL: begin aluop = ALU_SLL; is_shift = 1'b1; end
                FN_SRL: begin aluop = ALU_SRL; is_shift = 1'b1; end
                FN_SRA: begin aluop = ALU_SRA; is_shift = 1'b1; end
                default:         legal = 1'b0;
            endcase
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin aluop = ALU_ADD; extop = 1'b1; end
            OP_SLTI:          begin aluop = ALU_SLT; extop = 1'b1; end
            OP_BEQ, OP_BNE:   begin aluop = ALU_SUB; extop = 1'b1; end
            OP_ANDI:          aluop = ALU_AND;
            OP_ORI:           aluop = ALU_OR;
            OP_XORI:          aluop = ALU_XOR;
            OP_LUI:           aluop = ALU_LUI;
            OP_J:             aluop = ALU_NOP;
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state, state_nx;
    logic [3:0] dec_aluop;
    logic       dec_ext, dec_shift, dec_legal;

    mc_ctrl_alu_dec alu_dec (
        .Op       (Op),
        .Funct    (Funct),
        .aluop    (dec_aluop),
        .extop    (dec_ext),
        .is_shift (dec_shift),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= S_FETCH;
        else       state <= state_nx;

    assign State = state;

    always_comb begin
        state_nx = S_FETCH;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        WDSel    = 2'd0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        EXTOp    = 1'b0;
        PCSource = 2'd0;
        ALUOp    = ALU_NOP;
        Illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
                ALUSrcB  = 2'd1;
                ALUOp    = ALU_ADD;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB  = 2'd3;
                EXTOp    = 1'b1;
                ALUOp    = ALU_ADD;
                Illegal  = ~dec_legal;
                state_nx = !dec_legal                  ? S_FETCH  :
                           (Op == OP_LW || Op == OP_SW)  ? S_MEMADR :
                           (Op == OP_RTYPE)              ? S_REXEC  :
                           (Op == OP_BEQ || Op == OP_BNE) ? S_BRANCH :
                           (Op == OP_J)                  ? S_JUMP   : S_IEXEC;
            end
            S_MEMADR: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = 2'd2;
                EXTOp    = 1'b1;
                ALUOp    = ALU_ADD;
                state_nx = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                WDSel    = 2'd1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA  = dec_shift ? 2'd2 : 2'd1;
                ALUOp    = dec_aluop;
                state_nx = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'd1;
            end
            S_IEXEC: begin
                ALUSrcA  = 2'd1;
                ALUSrcB  = 2'd2;
                EXTOp    = dec_ext;
                ALUOp    = dec_aluop;
                state_nx = S_IWB;
            end
            S_IWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 2'd1;
                ALUOp    = ALU_SUB;
                PCSource = 2'd1;
                PCWrite  = (Op == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of the multicycle control FSM sequences and outputs
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, Illegal;
    logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp, State;
    int         n_tests = 0;
    int         n_fail  = 0;

    mc_ctrl dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .PCSource(PCSource),
        .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("write_exclusive", {31'd0, (RegWrite + MemWrite + PCWrite) > 2'd1}, 0);
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [3:0] alu, input logic [1:0] srca);
        Op = 6'h00; Funct = fn;
        step();
        check("r_decode_illegal", Illegal, 0);
        step();
        check("rexec_state", State, 6);
        check("rexec_aluop", ALUOp, alu);
        check("rexec_srca", ALUSrcA, srca);
        check("rexec_srcb", ALUSrcB, 0);
        step();
        check("rwb_state", State, 7);
        check("rwb_regwrite", RegWrite, 1);
        check("rwb_regdst", RegDst, 1);
        check("rwb_wdsel", WDSel, 0);
        step();
        check("r_back_fetch", State, 0);
    endtask

    task automatic run_i(input logic [5:0] op, input logic [3:0] alu, input logic ext);
        Op = op; Funct = 6'h3F;
        step();
        step();
        check("iexec_state", State, 8);
        check("iexec_aluop", ALUOp, alu);
        check("iexec_extop", EXTOp, ext);
        check("iexec_srca", ALUSrcA, 1);
        check("iexec_srcb", ALUSrcB, 2);
        step();
        check("iwb_regwrite", RegWrite, 1);
        check("iwb_regdst", RegDst, 0);
        check("iwb_wdsel", WDSel, 0);
        step();
        check("i_back_fetch", State, 0);
    endtask

    task automatic run_br(input logic [5:0] op, input logic z, input logic exp_pcw);
        Op = op; Zero = ~z;
        step();
        Zero = z;
        step();
        check("branch_state", State, 10);
        check("branch_pcwrite", PCWrite, exp_pcw);
        check("branch_pcsource", PCSource, 1);
        check("branch_aluop", ALUOp, ALU_SUB);
        step();
        check("branch_back_fetch", State, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", State, 0);
        check("reset_pcwrite", PCWrite, 1);
        check("reset_aluop", ALUOp, ALU_ADD);
        check("reset_srcb", ALUSrcB, 1);
        check("reset_memread_irwrite", {MemRead, IRWrite}, 2'b11);
        check("reset_others", {IorD, MemWrite, RegWrite, RegDst, WDSel, ALUSrcA, EXTOp, PCSource, Illegal}, 0);
        rstn = 1'b1;
        step();
        check("lw_c2_decode", State, 1);
        check("lw_c2_srcb", ALUSrcB, 3);
        step();
        check("lw_c3_memadr", State, 2);
        check("lw_c3_srca_srcb", {ALUSrcA, ALUSrcB}, 4'b0110);
        check("lw_c3_extop", EXTOp, 1);
        step();
        check("lw_c4_state", State, 3);
        check("lw_c4_memread", MemRead, 1);
        check("lw_c4_iord", IorD, 1);
        step();
        check("lw_c5_state", State, 4);
        check("lw_c5_regwrite", RegWrite, 1);
        check("lw_c5_wdsel", WDSel, 1);
        check("lw_c5_regdst", RegDst, 0);
        step();
        check("lw_c6_fetch", State, 0);
        check("lw_c6_memread", MemRead, 1);

        run_r(6'h00, ALU_SLL, 2);
        run_r(6'h03, ALU_SRA, 2);
        run_r(6'h02, ALU_SRL, 2);
        run_r(6'h20, ALU_ADD, 1);
        run_r(6'h23, ALU_SUB, 1);
        run_r(6'h2A, ALU_SLT, 1);
        run_r(6'h2B, ALU_SLTU, 1);
        run_r(6'h27, ALU_NOR, 1);
        run_r(6'h26, ALU_XOR, 1);

        run_i(6'h08, ALU_ADD, 1);
        run_i(6'h0A, ALU_SLT, 1);
        run_i(6'h0C, ALU_AND, 0);
        run_i(6'h0D, ALU_OR, 0);
        run_i(6'h0F, ALU_LUI, 0);

        run_br(6'h04, 1'b1, 1'b1);
        run_br(6'h04, 1'b0, 1'b0);
        run_br(6'h05, 1'b1, 1'b0);
        run_br(6'h05, 1'b0, 1'b1);

        Op = 6'h02;
        step();
        step();
        check("jump_state", State, 12);
        check("jump_pcwrite", PCWrite, 1);
        check("jump_pcsource", PCSource, 2);
        step();
        check("jump_back_fetch", State, 0);

        Op = 6'h3F;
        check("ill_fetch_illegal", Illegal, 0);
        step();
        check("ill_decode_illegal", Illegal, 1);
        check("ill_decode_writes", {RegWrite, MemWrite}, 0);
        step();
        check("ill_back_fetch", State, 0);
        check("ill_fetch_illegal_low", Illegal, 0);
        check("ill_fetch_writes", {RegWrite, MemWrite}, 0);

        Op = 6'h00; Funct = 6'h3F;
        step();
        check("bad_funct_illegal", Illegal, 1);
        step();
        check("bad_funct_fetch", State, 0);

        Op = 6'h2B;
        step();
        step();
        step();
        check("sw_memwr_state", State, 5);
        check("sw_memwrite", MemWrite, 1);
        check("sw_iord", IorD, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_memwrite_drop", MemWrite, 0);
        check("rst_state_fetch", State, 0);
        step();
        check("rst_hold_state", State, 0);
        check("rst_hold_memwrite", MemWrite, 0);
        rstn = 1'b1;
        step();
        check("rst_release_decode", State, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

- Multicycle control FSM for the student MIPS CPU.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the `ALUOp` encoding consumed by `alu`, plus datapath select and write-enable lines.
- Sits between the instruction register (Op/Funct) and the shared-memory multicycle datapath.

## Interface

Parameters:
- none. All encodings come from `ctrl_encode_def.v`.

Ports:
- `clk`  in  1  — system clock, rising edge.
- `rstn`  in  1  — asynchronous, active-low reset.
- `Op`  in  6  — IR[31:26]; stable from the end of FETCH until the next FETCH.
- `Funct`  in  6  — IR[5:0].
- `Zero`  in  1  — `alu` Zero flag, same cycle.
- `PCWrite`  out  1  — PC load enable, final (includes branch qualification).
- `IRWrite`  out  1  — IR load enable.
- `IorD`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  — memory read strobe.
- `MemWrite`  out  1  — memory write strobe.
- `RegWrite`  out  1  — register file write enable.
- `RegDst`  out  2  — destination register: 0 = rt, 1 = rd.
- `WDSel`  out  2  — writeback source: 0 = ALUOut, 1 = MDR.
- `ALUSrcA`  out  2  — ALU A source: 0 = PC, 1 = rs, 2 = zero-extended shamt.
- `ALUSrcB`  out  2  — ALU B source: 0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2.
- `EXTOp`  out  1  — immediate extension: 1 = sign, 0 = zero.
- `PCSource`  out  2  — next-PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `ALUOp`  out  4  — `ALU_*` code.
- `Illegal`  out  1  — one-cycle pulse on an unsupported encoding.
- `State`  out  4  — current state, for debug.

## Operation

- Supported instructions:
  - R-type: add/addu, sub/subu, and, or, nor, xor, slt, sltu, sll, srl, sra.
  - I-type: addi/addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne, j.
- Encoding: 4-bit one-hot-free binary state register.
- Outputs are combinational from `State`, `Op`, `Funct` and `Zero`.
- Every output not listed for a state is 0, except `ALUOp` = `ALU_NOP`.

States and transitions:
- FETCH
  - Asserts `MemRead`, `IRWrite`, `PCWrite`.
  - `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=`ALU_ADD`, `PCSource`=0.
  - Next: DECODE.
- DECODE
  - `ALUSrcA`=0, `ALUSrcB`=3, `EXTOp`=1, `ALUOp`=`ALU_ADD` (branch target into ALUOut).
  - Next by `Op`: lw/sw → MEMADR; R-type → REXEC; I-ALU → IEXEC; beq/bne → BRANCH; j → JUMP.
  - Any other `Op`, or R-type with an unsupported `Funct`: pulse `Illegal`, next FETCH (treated as NOP).
- MEMADR
  - `ALUSrcA`=1, `ALUSrcB`=2, `EXTOp`=1, `ALUOp`=`ALU_ADD`.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`, `IorD`=1. Next: MEMWB.
- MEMWB: `RegWrite`, `RegDst`=0, `WDSel`=1. Next: FETCH.
- MEMWR: `MemWrite`, `IorD`=1. Next: FETCH.
- REXEC
  - `ALUSrcB`=0.
  - `ALUSrcA`=2 for sll/srl/sra, otherwise 1.
  - `ALUOp` from `Funct`: e.g. 0x20/0x21 → ADD, 0x2A → SLT, 0x00 → SLL, 0x03 → SRA.
  - Next: RWB.
- RWB: `RegWrite`, `RegDst`=1, `WDSel`=0. Next: FETCH.
- IEXEC
  - `ALUSrcA`=1, `ALUSrcB`=2.
  - `EXTOp`=1 for addi/addiu/slti, 0 for andi/ori/xori/lui.
  - `ALUOp`: lui → `ALU_LUI`.
  - Next: IWB.
- IWB: `RegWrite`, `RegDst`=0, `WDSel`=0. Next: FETCH.
- BRANCH
  - `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=`ALU_SUB`, `PCSource`=1.
  - `PCWrite` = `Zero` for beq, `~Zero` for bne.
  - Next: FETCH.
- JUMP: `PCWrite`, `PCSource`=2. Next: FETCH.

## Timing

- Reset (`rstn` low, asynchronous): `State` = FETCH immediately.
  - Outputs then read: `MemRead`=`IRWrite`=`PCWrite`=1, `ALUSrcB`=1, `ALUOp`=`ALU_ADD`, all others 0.
  - The datapath must hold PC/IR in reset as well.
- Reset deassertion mid-instruction always restarts at FETCH; no partial writeback occurs after reset.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, I-ALU: 4
  - beq/bne, j: 3
  - illegal: 2
- `Zero` is sampled only combinationally in BRANCH; it is ignored in all other states.
- `Illegal` is high for exactly the DECODE cycle.
- `RegWrite`, `MemWrite` and `PCWrite` are never asserted together in one cycle, except `PCWrite` with `IRWrite`/`MemRead` in FETCH.

## Structure

- State codes (FETCH=0 … JUMP=12) and Op/Funct constants go in shared `ctrl_encode_def.v`, alongside the existing `ALU_*` codes.
- One sub-module: `alu_dec`, a combinational (`Op`, `Funct`) → `ALUOp`/`EXTOp`/`is_shift`/`legal` decoder.
  - Used for the REXEC and IEXEC outputs and for the DECODE legality check.

## Test plan

- Reset: hold `rstn`=0, then release.
  - Requires `State`=0, `PCWrite`=1, `ALUOp`=`ALU_ADD`; second cycle `State`=DECODE.
- lw (`Op`=0x23):
  - Requires 5 cycles with `MemRead` in cycles 1 and 4, `IorD`=1 in cycle 4.
  - Cycle 5: `RegWrite`=1, `WDSel`=1, `RegDst`=0; cycle 6 back in FETCH.
- sll (`Op`=0, `Funct`=0x00):
  - Requires REXEC with `ALUSrcA`=2, `ALUOp`=`ALU_SLL`.
  - RWB with `RegDst`=1; 4 cycles total.
- beq with `Zero`=1, then `Zero`=0:
  - Requires BRANCH `PCWrite`=1 then 0, with `PCSource`=1 both times.
  - bne inverts both results.
- Unsupported `Op`=0x3F:
  - Requires `Illegal`=1 in DECODE only; FETCH next; no `RegWrite`/`MemWrite` ever asserted.
- Reset asserted during MEMWR:
  - Requires `MemWrite` to drop at once and `State`=FETCH while `rstn`=0.
